perf_trace: RTL and testbench
=============================

PERF_TRACE -- requirements
Module: perf_trace

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, trace FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter MAX_CYCLES, default 30, run cycles recorded before the run ends (1..65535).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_i  input  1  CPU start; 1 = count and record this cycle.
REQ-006 SHALL have port pc_i  input  32  current CPU PC value.
REQ-007 SHALL have port stall_i  input  1  hazard unit stall indication.
REQ-008 SHALL have port flush_i  input  1  pipeline flush indication.
REQ-009 SHALL have port rec_ready_i  input  1  trace consumer accepts the head record.
REQ-010 SHALL have port rec_valid_o  output  1  head record valid.
REQ-011 SHALL have port rec_cycle_o  output  16  head record: cycle index.
REQ-012 SHALL have port rec_pc_o  output  32  head record: PC.
REQ-013 SHALL have port rec_stall_o  output  16  head record: cumulative stalls.
REQ-014 SHALL have port rec_flush_o  output  16  head record: cumulative flushes.
REQ-015 SHALL have port drop_cnt_o  output  16  records lost to a full FIFO, saturating.
REQ-016 SHALL have port overflow_o  output  1  sticky: at least one record dropped.
REQ-017 SHALL have port done_o  output  1  run complete and FIFO drained.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN, DONE; IDLE->RUN when start_i=1 (that cycle is recorded as cycle 0).
REQ-019 SHALL, in RUN with start_i=1, capture a record: cycle = current cycle count; stall/flush counts include this cycle's events; then increment cycle count.
REQ-020 SHALL treat a stall event as stall_i=1 and flush_i=0; a flush event as flush_i=1; both 1 counts a flush only.
REQ-021 SHALL, in RUN with start_i=0, pause: no count, no record, state held.
REQ-022 SHALL go RUN->DRAIN on the cycle capturing cycle index MAX_CYCLES-1, DRAIN->DONE when FIFO empty; DONE holds until reset.
REQ-023 SHALL present a pushed record on rec_* with rec_valid_o=1 one cycle after capture, when the FIFO was empty (1-cycle latency).
REQ-024 SHALL pop the head on a rising edge with rec_valid_o=1 and rec_ready_i=1; rec_* SHALL stay stable while rec_valid_o=1 and rec_ready_i=0.
REQ-025 SHALL, on push into a full FIFO with no pop that cycle, drop the record, increment drop_cnt_o (saturate at 65535) and set overflow_o.
REQ-026 SHALL, on simultaneous push and pop when full, accept both; no drop.
REQ-027 SHALL saturate stall and flush counters at 65535; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL drive done_o=1 only in DONE.

Reset
REQ-029 SHALL, with rst_n_i=0 at a rising edge, go to IDLE, empty the FIFO and clear all counters, overflow_o, done_o and rec_valid_o; rec_* data SHALL read 0.
REQ-030 SHALL, on reset mid-RUN or mid-DRAIN, discard pending records; the next run starts at cycle 0.

Configuration
REQ-031 SHALL, with PERF_TRACE_FILTER_EN defined, push only records whose cycle has a stall or flush event, plus cycle 0 and cycle MAX_CYCLES-1; cycle count still advances every RUN cycle.
REQ-032 SHALL, without PERF_TRACE_FILTER_EN, push a record every RUN cycle with start_i=1.

Verification
REQ-033 SHALL cover: start_i=1 for 30 cycles, rec_ready_i=1, pc_i=4*n -> 30 records, cycles 0..29, PC 0..116, done_o=1 on the cycle after the last pop.
REQ-034 SHALL cover: stall_i=1 in cycles 3 and 4, flush_i=1 in cycle 7 -> record 4 shows stall=2, record 7 shows flush=1, stall=2.
REQ-035 SHALL cover: rec_ready_i=0 throughout a 30-cycle run, FIFO_DEPTH=8 -> 8 records held, drop_cnt_o=22, overflow_o=1, state DRAIN until ready.
REQ-036 SHALL cover: start_i deasserted in cycles 5..9 -> no records or count change; cycle indices stay contiguous.
REQ-037 SHALL cover: rst_n_i=0 at cycle 12 -> all outputs 0 next cycle; a restarted run emits cycle 0 first.
REQ-038 SHALL cover: PERF_TRACE_FILTER_EN defined, one stall at cycle 10 -> exactly 3 records: cycles 0, 10, 29.

Source files
------------

// File: rtl/perf_trace.sv
// perf_trace: per-cycle CPU trace recorder (cycle, PC, cumulative stalls/flushes) feeding a record FIFO.
// Define PERF_TRACE_FILTER_EN to push only event cycles plus the first and last run cycle.
module perf_trace #(
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_CYCLES = 30
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        rec_ready_i,
   output logic        rec_valid_o,
   output logic [15:0] rec_cycle_o,
   output logic [31:0] rec_pc_o,
   output logic [15:0] rec_stall_o,
   output logic [15:0] rec_flush_o,
   output logic [15:0] drop_cnt_o,
   output logic        overflow_o,
   output logic        done_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      LAST_CYCLE = 16'(MAX_CYCLES - 1);
   localparam logic [15:0]      SAT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   typedef struct packed {
      logic [15:0] cycle;
      logic [31:0] pc;
      logic [15:0] stalls;
      logic [15:0] flushes;
   } rec_t;

   state_t           state_reg;
   logic             done_reg;
   logic [15:0]      cycle_reg;
   logic [15:0]      stall_reg;
   logic [15:0]      flush_reg;
   logic [15:0]      drop_reg;
   logic             overflow_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   rec_t             mem_reg [FIFO_DEPTH];

   logic             capture;
   logic             ev_stall;
   logic             ev_flush;
   logic             last_cycle;
   logic             want_push;
   logic             push_ok;
   logic             drop;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [15:0]      stall_next;
   logic [15:0]      flush_next;
   logic [CNT_W-1:0] count_next;
   rec_t             rec_in;
   rec_t             head;

   // A cycle with both stall and flush counts as a flush only.
   assign ev_flush   = flush_i;
   assign ev_stall   = stall_i & ~flush_i;
   assign capture    = start_i && ((state_reg == ST_IDLE) || (state_reg == ST_RUN));
   assign last_cycle = (cycle_reg == LAST_CYCLE);

   assign stall_next = (capture && ev_stall && (stall_reg != SAT_MAX)) ? stall_reg + 16'd1 : stall_reg;
   assign flush_next = (capture && ev_flush && (flush_reg != SAT_MAX)) ? flush_reg + 16'd1 : flush_reg;

`ifdef PERF_TRACE_FILTER_EN
   assign want_push = capture && (ev_stall || ev_flush || (cycle_reg == 16'd0) || last_cycle);
`else
   assign want_push = capture;
`endif

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == FULL_CNT);
   assign pop        = !fifo_empty && rec_ready_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok    = want_push && (!fifo_full || pop);
   assign drop       = want_push && fifo_full && !pop;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push_ok) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_comb begin
      rec_in.cycle   = cycle_reg;
      rec_in.pc      = pc_i;
      rec_in.stalls  = stall_next;
      rec_in.flushes = flush_next;
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= rec_in;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_reg    <= ST_IDLE;
         done_reg     <= 1'b0;
         cycle_reg    <= '0;
         stall_reg    <= '0;
         flush_reg    <= '0;
         drop_reg     <= '0;
         overflow_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         stall_reg <= stall_next;
         flush_reg <= flush_next;
         count_reg <= count_next;
         if (capture) begin
            cycle_reg <= cycle_reg + 16'd1;
         end
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_reg != SAT_MAX) begin
               drop_reg <= drop_reg + 16'd1;
            end
         end

         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  state_reg <= last_cycle ? ST_DRAIN : ST_RUN;
               end
            end
            ST_RUN: begin
               if (capture && last_cycle) begin
                  state_reg <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Finish in the same edge that pops the final record.
               if (count_next == '0) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end
            end
            ST_DONE: begin
               done_reg <= 1'b1;
            end
            default: begin
               state_reg <= ST_IDLE;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign head = mem_reg[rd_ptr_reg];

   assign rec_valid_o = !fifo_empty;
   assign rec_cycle_o = fifo_empty ? 16'd0 : head.cycle;
   assign rec_pc_o    = fifo_empty ? 32'd0 : head.pc;
   assign rec_stall_o = fifo_empty ? 16'd0 : head.stalls;
   assign rec_flush_o = fifo_empty ? 16'd0 : head.flushes;
   assign drop_cnt_o  = drop_reg;
   assign overflow_o  = overflow_reg;
   assign done_o      = done_reg;

endmodule

// File: tb/tb_perf_trace.sv
// tb_perf_trace: directed tables, multi-cycle sequences and random runs checked against a queue-based model.
// Under PERF_TRACE_FILTER_EN the model filters pushes and the filter-specific sequence runs.
module tb_perf_trace;

   localparam int DEPTH = 8;
   localparam int MAXC  = 30;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        rec_ready_i = 1'b0;
   logic        rec_valid_o;
   logic [15:0] rec_cycle_o;
   logic [31:0] rec_pc_o;
   logic [15:0] rec_stall_o;
   logic [15:0] rec_flush_o;
   logic [15:0] drop_cnt_o;
   logic        overflow_o;
   logic        done_o;

   perf_trace #(.FIFO_DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .pc_i(pc_i),
      .stall_i(stall_i), .flush_i(flush_i), .rec_ready_i(rec_ready_i),
      .rec_valid_o(rec_valid_o), .rec_cycle_o(rec_cycle_o), .rec_pc_o(rec_pc_o),
      .rec_stall_o(rec_stall_o), .rec_flush_o(rec_flush_o),
      .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned cyc;
      logic [31:0] pc;
      int unsigned st;
      int unsigned fl;
   } mrec_t;

   mrec_t       mq[$];
   int          m_phase;   // 0 idle, 1 running, 2 draining, 3 done
   int unsigned m_cyc, m_st, m_fl, m_drop;
   bit          m_ovf;
   int unsigned popped_cycles[$];

   typedef struct {
      bit          stall;
      bit          flush;
      int unsigned exp_cycle;
      logic [31:0] exp_pc;
      int unsigned exp_st;
      int unsigned exp_fl;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned sat16(input int unsigned v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_edge(input bit rst, input bit st, input bit sl, input bit fl, input bit rdy,
                             input logic [31:0] pc);
      int    old_phase;
      bit    keep;
      mrec_t r;
      if (rst) begin
         mq.delete();
         m_phase = 0; m_cyc = 0; m_st = 0; m_fl = 0; m_drop = 0; m_ovf = 0;
         return;
      end
      old_phase = m_phase;
      if (mq.size() > 0 && rdy) begin
         r = mq.pop_front();
         popped_cycles.push_back(r.cyc);
         $display("pop: cycle=%0d pc=%08h stalls=%0d flushes=%0d", r.cyc, r.pc, r.st, r.fl);
      end
      if (st && (old_phase == 0 || old_phase == 1)) begin
         if (fl) m_fl = sat16(m_fl + 1);
         else if (sl) m_st = sat16(m_st + 1);
         r.cyc = m_cyc; r.pc = pc; r.st = m_st; r.fl = m_fl;
         keep = 1'b1;
`ifdef PERF_TRACE_FILTER_EN
         keep = sl || fl || (m_cyc == 0) || (m_cyc == MAXC - 1);
`endif
         if (keep) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
               m_drop = sat16(m_drop + 1);
               m_ovf  = 1'b1;
            end
         end
         m_phase = (m_cyc == MAXC - 1) ? 2 : 1;
         m_cyc++;
      end
      if (old_phase == 2 && mq.size() == 0) m_phase = 3;
   endtask

   task automatic compare_all();
      bit    v;
      mrec_t h;
      v = (mq.size() > 0);
      if (v) h = mq[0];
      else begin
         h.cyc = 0; h.pc = '0; h.st = 0; h.fl = 0;
      end
      check("rec_valid", rec_valid_o, v);
      check("rec_cycle", rec_cycle_o, h.cyc);
      check("rec_pc",    rec_pc_o,    h.pc);
      check("rec_stall", rec_stall_o, h.st);
      check("rec_flush", rec_flush_o, h.fl);
      check("drop_cnt",  drop_cnt_o,  m_drop);
      check("overflow",  overflow_o,  m_ovf);
      check("done",      done_o,      (m_phase == 3));
   endtask

   // Drives one cycle of inputs, advances DUT and model across the edge, then compares.
   task automatic step(input bit rst, input bit st, input bit sl, input bit fl, input bit rdy,
                       input logic [31:0] pc);
      rst_n_i = !rst; start_i = st; stall_i = sl; flush_i = fl; rec_ready_i = rdy; pc_i = pc;
      @(posedge clk_i);
      model_edge(rst, st, sl, fl, rdy, pc);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, '0);
      step(1, 0, 0, 0, 0, '0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int n = 0; n < 10; n++) begin
         tbl[n].stall     = (n == 3 || n == 4);
         tbl[n].flush     = (n == 7);
         tbl[n].exp_cycle = n;
         tbl[n].exp_pc    = 32'(4 * n);
         tbl[n].exp_st    = (n < 3) ? 0 : ((n == 3) ? 1 : 2);
         tbl[n].exp_fl    = (n < 7) ? 0 : 1;
      end

      // Reset state, with inputs active to make sure reset dominates.
      rst_n_i = 1'b0; start_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1; rec_ready_i = 1'b1;
      @(posedge clk_i);
      model_edge(1, 0, 0, 0, 0, '0);
      #1;
      check("reset_valid", rec_valid_o, 1'b0);
      check("reset_cycle", rec_cycle_o, 16'd0);
      check("reset_pc",    rec_pc_o,    32'd0);
      check("reset_stall", rec_stall_o, 16'd0);
      check("reset_flush", rec_flush_o, 16'd0);
      check("reset_drop",  drop_cnt_o,  16'd0);
      check("reset_ovf",   overflow_o,  1'b0);
      check("reset_done",  done_o,      1'b0);
      do_reset();

      // Full run with ready=1, pc=4n, stalls in cycles 3,4 and a flush in cycle 7.
      for (int n = 0; n < MAXC; n++) begin
         if (n < 10) begin
            step(0, 1, tbl[n].stall, tbl[n].flush, 1, 32'(4 * n));
`ifndef PERF_TRACE_FILTER_EN
            check("tbl_valid", rec_valid_o, 1'b1);
            check("tbl_cycle", rec_cycle_o, tbl[n].exp_cycle);
            check("tbl_pc",    rec_pc_o,    tbl[n].exp_pc);
            check("tbl_stall", rec_stall_o, tbl[n].exp_st);
            check("tbl_flush", rec_flush_o, tbl[n].exp_fl);
`endif
         end else begin
            step(0, 1, 0, 0, 1, 32'(4 * n));
         end
      end
      check("run_last_cycle", rec_cycle_o, 16'd29);
      check("run_last_pc",    rec_pc_o,    32'd116);
      check("run_not_done",   done_o,      1'b0);
      step(0, 0, 0, 0, 1, '0);
      check("run_done_after_pop", done_o, 1'b1);
      step(0, 1, 0, 0, 1, 32'h1234);
      check("done_holds", done_o, 1'b1);

      // Consumer never ready: FIFO holds DEPTH records, the rest are dropped.
      do_reset();
      for (int n = 0; n < MAXC; n++) step(0, 1, 0, 0, 0, 32'(4 * n));
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, '0);
`ifndef PERF_TRACE_FILTER_EN
      check("full_drop_cnt", drop_cnt_o, 16'd22);
      check("full_overflow", overflow_o, 1'b1);
      check("full_head",     rec_cycle_o, 16'd0);
`endif
      check("full_not_done", done_o, 1'b0);
      for (int k = 0; k < DEPTH + 2; k++) step(0, 0, 0, 0, 1, '0);
      check("full_drained_done", done_o, 1'b1);

      // Start paused in cycles 5..9: indices stay contiguous.
      do_reset();
      for (int n = 0; n < 15; n++) begin
         step(0, !(n >= 5 && n <= 9), 0, 0, 1, 32'(100 + n));
`ifndef PERF_TRACE_FILTER_EN
         if (n == 10) check("pause_resume_cycle", rec_cycle_o, 16'd5);
`endif
      end

      // Reset mid-run at cycle 12, then restart.
      do_reset();
      for (int n = 0; n < 12; n++) step(0, 1, n[0], 0, n[1], 32'(n));
      step(1, 1, 1, 1, 0, 32'hFFFF_FFFF);
      check("midreset_valid", rec_valid_o, 1'b0);
      check("midreset_cycle", rec_cycle_o, 16'd0);
      check("midreset_stall", rec_stall_o, 16'd0);
      check("midreset_drop",  drop_cnt_o,  16'd0);
      check("midreset_done",  done_o,      1'b0);
      step(0, 1, 0, 0, 0, 32'h40);
      check("restart_valid", rec_valid_o, 1'b1);
      check("restart_cycle", rec_cycle_o, 16'd0);
      check("restart_pc",    rec_pc_o,    32'h40);

`ifdef PERF_TRACE_FILTER_EN
      // One stall at cycle 10: only cycles 0, 10 and 29 are recorded.
      do_reset();
      popped_cycles.delete();
      for (int n = 0; n < MAXC; n++) step(0, 1, (n == 10), 0, 1, 32'(4 * n));
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, '0);
      check("filter_count", popped_cycles.size(), 3);
      if (popped_cycles.size() == 3) begin
         check("filter_rec0", popped_cycles[0], 0);
         check("filter_rec1", popped_cycles[1], 10);
         check("filter_rec2", popped_cycles[2], 29);
      end
      check("filter_done", done_o, 1'b1);
`endif

      // Random runs against the model.
      for (int run = 0; run < 4; run++) begin
         int steps;
         do_reset();
         steps = 0;
         while (m_phase != 3 && steps < 400) begin
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom);
            steps++;
         end
         check("random_run_done", done_o, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
